// File: rtl/circuito_total_pkg.sv
// circuito_total_pkg: shared choice encodings, widths and the rock-paper-scissors beat rule.
package circuito_total_pkg;
    localparam int CHOICE_W = 2;
    localparam int SCORE_W  = 7;
    localparam int NPLAYERS = 4;

    localparam logic [CHOICE_W-1:0] ROCK     = 2'd0;
    localparam logic [CHOICE_W-1:0] PAPER    = 2'd1;
    localparam logic [CHOICE_W-1:0] SCISSORS = 2'd2;
    localparam logic [CHOICE_W-1:0] INVALID  = 2'd3;

    // Winning choice when exactly two distinct valid choices are present
    function automatic logic [CHOICE_W-1:0] beater(input logic [3:0] has);
        return has[PAPER] ? (has[SCISSORS] ? SCISSORS : PAPER) : ROCK;
    endfunction
endpackage

// File: rtl/circuito_total_rps_winner.sv
// rps_winner: maps four player choices to the round-winner mask.
module rps_winner
    import circuito_total_pkg::*;
(
    input  logic [CHOICE_W-1:0] j1_i,
    input  logic [CHOICE_W-1:0] j2_i,
    input  logic [CHOICE_W-1:0] j3_i,
    input  logic [CHOICE_W-1:0] j4_i,
    output logic [NPLAYERS-1:0] win_o
);
    logic [NPLAYERS*CHOICE_W-1:0] j;
    logic [3:0]                   has;
    logic [CHOICE_W-1:0]          beat;
    logic                         decided;

    assign j = {j4_i, j3_i, j2_i, j1_i};

    always_comb begin
        has = '0;
        for (int i = 0; i < NPLAYERS; i++) has[j[i*CHOICE_W +: CHOICE_W]] = 1'b1;
        beat    = beater(has);
        decided = !has[INVALID] && ($countones(has[2:0]) == 2);
        win_o   = '0;
        for (int i = 0; i < NPLAYERS; i++) win_o[i] = decided && (j[i*CHOICE_W +: CHOICE_W] == beat);
    end
endmodule

// File: rtl/circuito_total.sv
// circuito_total: registered round winners and their highest-score subset.
module circuito_total
    import circuito_total_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHOICE_W-1:0] J1,
    input  logic [CHOICE_W-1:0] J2,
    input  logic [CHOICE_W-1:0] J3,
    input  logic [CHOICE_W-1:0] J4,
    input  logic [SCORE_W-1:0]  Ap,
    input  logic [SCORE_W-1:0]  Bp,
    input  logic [SCORE_W-1:0]  Cp,
    input  logic [SCORE_W-1:0]  Dp,
    output logic [NPLAYERS-1:0] Vencedor1,
    output logic [NPLAYERS-1:0] Vencedor2
);
    logic [NPLAYERS-1:0] v1_d, v2_d, v1_q, v2_q;
    logic [SCORE_W-1:0]  score [NPLAYERS];
    logic [SCORE_W-1:0]  max_s;

    assign score[0] = Ap;
    assign score[1] = Bp;
    assign score[2] = Cp;
    assign score[3] = Dp;

    rps_winner u_rps_winner (
        .j1_i  (J1),
        .j2_i  (J2),
        .j3_i  (J3),
        .j4_i  (J4),
        .win_o (v1_d)
    );

    // Maximum is taken over round winners only; every tied maximum stays set
    always_comb begin
        max_s = '0;
        for (int i = 0; i < NPLAYERS; i++) if (v1_d[i] && score[i] > max_s) max_s = score[i];
        v2_d = '0;
        for (int i = 0; i < NPLAYERS; i++) v2_d[i] = v1_d[i] && (score[i] == max_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= '0;
            v2_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    assign Vencedor1 = v1_q;
    assign Vencedor2 = v2_q;
endmodule

// File: tb/tb_circuito_total.sv
// tb_circuito_total: scoreboard bench with directed choice vectors and reset checks.
module tb_circuito_total;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] J1, J2, J3, J4;
    logic [6:0] Ap, Bp, Cp, Dp;
    logic [3:0] Vencedor1, Vencedor2;
    logic [7:0] exp_q [$];
    logic [7:0] e;
    int         checks = 0;
    int         errors = 0;

    circuito_total dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .J1        (J1),
        .J2        (J2),
        .J3        (J3),
        .J4        (J4),
        .Ap        (Ap),
        .Bp        (Bp),
        .Cp        (Cp),
        .Dp        (Dp),
        .Vencedor1 (Vencedor1),
        .Vencedor2 (Vencedor2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: the registered result is due just after the edge following each applied vector
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("Vencedor1", Vencedor1, e[7:4]);
            chk("Vencedor2", Vencedor2, e[3:0]);
        end
    end

    task automatic apply(input logic [1:0] a, b, c, d, input logic [3:0] v1, v2);
        @(negedge clk);
        J1 = a; J2 = b; J3 = c; J4 = d;
        exp_q.push_back({v1, v2});
    endtask

    initial begin
        Ap = 7'd50; Bp = 7'd50; Cp = 7'd25; Dp = 7'd100;
        J1 = 2'd0; J2 = 2'd0; J3 = 2'd0; J4 = 2'd1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_v1", Vencedor1, 4'b0000);
        chk("reset_v2", Vencedor2, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold_v1", Vencedor1, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 0, 0, 0, 4'b0000, 4'b0000);
        apply(1, 1, 1, 1, 4'b0000, 4'b0000);
        apply(2, 2, 2, 2, 4'b0000, 4'b0000);
        apply(0, 0, 0, 1, 4'b1000, 4'b1000);
        apply(0, 0, 0, 2, 4'b0111, 4'b0011);
        apply(0, 0, 0, 2, 4'b0111, 4'b0011);
        apply(0, 0, 1, 1, 4'b1100, 4'b1000);
        apply(1, 1, 0, 0, 4'b0011, 4'b0011);
        apply(1, 2, 0, 0, 4'b0000, 4'b0000);
        apply(0, 0, 0, 3, 4'b0000, 4'b0000);
        apply(2, 1, 1, 1, 4'b0001, 4'b0001);
        apply(2, 2, 1, 1, 4'b0011, 4'b0011);
        apply(0, 2, 2, 2, 4'b0001, 4'b0001);
        apply(0, 0, 1, 1, 4'b1100, 4'b1000);
        @(negedge clk);
        chk("pre_reset_v1", Vencedor1, 4'b1100);
        rst_n = 1'b0;
        #1;
        chk("midreset_v1", Vencedor1, 4'b0000);
        chk("midreset_v2", Vencedor2, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 0, 0, 1, 4'b1000, 4'b1000);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
